// File: rtl/mfe_if.sv
// Median filter engine bus bundle: start handshake, image ROM read port
// and result RAM write port.
interface mfe_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic [DW-1:0] data_rd;
  logic [DW-1:0] data_wr;
  logic [AW-1:0] addr;
  logic          wen;

  // Engine side: masters both memory ports and reports busy.
  modport master (
    input  ready, idata, data_rd,
    output busy, iaddr, data_wr, addr, wen
  );

  // Host / memory side.
  modport slave (
    output ready, idata, data_rd,
    input  busy, iaddr, data_wr, addr, wen
  );
endinterface

// File: rtl/mfe.sv
// Median filter engine: 3x3 median over an IMG_W x IMG_H 8-bit image with
// zero padding. Pixels are processed in raster order; a sliding 3x3 window
// is refilled with one new right column per pixel (two columns at row start),
// the median comes from a 19-stage compare-exchange network and is written
// to the result RAM for one cycle.
module mfe #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic  clk,
  input  logic  reset,
  mfe_if.master bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [AW-1:0] P_LAST = AW'(IMG_W * IMG_H - 1);

  // Compare-exchange pairs of the 9-input median network; after the last
  // stage element 4 holds the 5th smallest value.
  localparam logic [3:0] CE_LO [19] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1,
                                        4'd4, 4'd7, 4'd0, 4'd5, 4'd4, 4'd3, 4'd1,
                                        4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
  localparam logic [3:0] CE_HI [19] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2,
                                        4'd5, 4'd8, 4'd3, 4'd8, 4'd7, 4'd6, 4'd4,
                                        4'd5, 4'd7, 4'd2, 4'd4, 4'd2};

  typedef enum logic [2:0] {IDLE, FETCH, SORT, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic [RW-1:0]       r_q, r_d;
  logic [CW-1:0]       c_q, c_d;
  logic [AW-1:0]       pix_q, pix_d;
  logic [2:0]          k_q, k_d;
  logic [AW-1:0]       iaddr_q, iaddr_d;
  logic [8:0][DW-1:0]  win_q, win_d;
  logic [DW-1:0]       med_q, med_d;

  logic [8:0][DW-1:0]  net [20];
  logic [3:0]          cur_pos;
  logic                cur_pad;
  logic                fetch_last;
  logic                col_wrap;
  logic [RW-1:0]       nr;
  logic [CW-1:0]       nc;
  logic                unused_rd;

  // Fetch k of a pixel: at row start (c==0) taps 0..5 fill window columns 1
  // and 2 (column 0 is padding); otherwise taps 0..2 fill column 2.
  function automatic int tap_wrow(input logic [2:0] k);
    return (k < 3'd3) ? int'(k) : int'(k) - 3;
  endfunction

  function automatic int tap_wcol(input logic [CW-1:0] c, input logic [2:0] k);
    if (k < 3'd3) return (c == '0) ? 1 : 2;
    return 2;
  endfunction

  function automatic logic [3:0] tap_pos(input logic [CW-1:0] c, input logic [2:0] k);
    return 4'(tap_wrow(k) * 3 + tap_wcol(c, k));
  endfunction

  function automatic logic tap_pad(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                   input logic [2:0] k);
    int ir, ic;
    ir = int'(r) + tap_wrow(k) - 1;
    ic = int'(c) + tap_wcol(c, k) - 1;
    return (ir < 0) || (ir >= IMG_H) || (ic < 0) || (ic >= IMG_W);
  endfunction

  // Padded taps keep the previous ROM address so they never cause a read.
  function automatic logic [AW-1:0] issue_addr(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                               input logic [2:0] k, input logic [AW-1:0] hold);
    int ir, ic;
    ir = int'(r) + tap_wrow(k) - 1;
    ic = int'(c) + tap_wcol(c, k) - 1;
    if (tap_pad(r, c, k)) return hold;
    return AW'(ir * IMG_W + ic);
  endfunction

  function automatic logic [8:0][DW-1:0] ce(input logic [8:0][DW-1:0] v,
                                            input logic [3:0] lo, input logic [3:0] hi);
    logic [8:0][DW-1:0] o;
    o = v;
    if (v[lo] > v[hi]) begin
      o[lo] = v[hi];
      o[hi] = v[lo];
    end
    return o;
  endfunction

  assign net[0] = win_q;
  for (genvar gi = 0; gi < 19; gi++) begin : g_ce
    assign net[gi+1] = ce(net[gi], CE_LO[gi], CE_HI[gi]);
  end

  assign unused_rd = ^bus.data_rd;

  // Next-state, window and address sequencing for the pixel loop.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    r_d      = r_q;
    c_d      = c_q;
    pix_d    = pix_q;
    k_d      = k_q;
    iaddr_d  = iaddr_q;
    win_d    = win_q;
    med_d    = med_q;

    cur_pos    = tap_pos(c_q, k_q);
    cur_pad    = tap_pad(r_q, c_q, k_q);
    fetch_last = (c_q == '0) ? (k_q == 3'd5) : (k_q == 3'd2);
    col_wrap   = (c_q == C_LAST);
    nc         = col_wrap ? '0 : c_q + 1'b1;
    nr         = col_wrap ? r_q + 1'b1 : r_q;

    case (state_q)
      IDLE: begin
        if (bus.ready) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          r_d     = '0;
          c_d     = '0;
          pix_d   = '0;
          k_d     = 3'd0;
          win_d   = '0;
          iaddr_d = issue_addr('0, '0, 3'd0, iaddr_q);
        end
      end
      FETCH: begin
        win_d[cur_pos] = cur_pad ? '0 : bus.idata;
        if (fetch_last) begin
          state_d = SORT;
        end else begin
          k_d     = k_q + 3'd1;
          iaddr_d = issue_addr(r_q, c_q, k_q + 3'd1, iaddr_q);
        end
      end
      SORT: begin
        med_d   = net[19][4];
        state_d = WRITE;
      end
      WRITE: begin
        if (pix_q == P_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          r_d     = '0;
          c_d     = '0;
          pix_d   = '0;
        end else begin
          state_d = FETCH;
          r_d     = nr;
          c_d     = nc;
          pix_d   = pix_q + 1'b1;
          k_d     = 3'd0;
          if (col_wrap) begin
            win_d = '0;
          end else begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = '0;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = '0;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = '0;
          end
          iaddr_d = issue_addr(nr, nc, 3'd0, iaddr_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      pix_q   <= '0;
      k_q     <= '0;
      iaddr_q <= '0;
      win_q   <= '0;
      med_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      r_q     <= r_d;
      c_q     <= c_d;
      pix_q   <= pix_d;
      k_q     <= k_d;
      iaddr_q <= iaddr_d;
      win_q   <= win_d;
      med_q   <= med_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.iaddr   = iaddr_q;
  assign bus.addr    = pix_q;
  assign bus.data_wr = med_q;
  assign bus.wen     = (state_q == WRITE);

endmodule

// File: tb/tb_mfe.sv
// Directed bench for the median filter engine on a reduced 16x12 image.
module tb_mfe;
  localparam int W    = 16;
  localparam int H    = 12;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mfe_if #(.AW(AW), .DW(DW)) bus ();

  mfe #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] rom  [NPIX];
  logic [7:0] expv [NPIX];
  logic [7:0] res  [NPIX];

  assign bus.idata   = rom[bus.iaddr];
  assign bus.data_rd = 8'h00;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int order_bad = 0;
  int next_addr = 0;
  int ckpt_bad = -1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference median: gather 9 zero-padded taps and insertion-sort them.
  function automatic logic [7:0] sw_med(input int r, input int c);
    logic [7:0] v [9];
    logic [7:0] t;
    int n = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr < 0 || r + dr >= H || c + dc < 0 || c + dc >= W) v[n] = 8'h00;
        else v[n] = rom[(r + dr) * W + c + dc];
        n = n + 1;
      end
    end
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (v[j-1] > v[j]) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
      end
    end
    return v[4];
  endfunction

  task automatic load_pattern(input int p);
    for (int i = 0; i < NPIX; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      case (p)
        0: rom[i] = 8'h00;
        1: rom[i] = 8'h80;
        2: rom[i] = (r == H / 2 && c == W / 2) ? 8'hFF : 8'h10;
        default: rom[i] = 8'((r + c) & 255);
      endcase
    end
    for (int i = 0; i < NPIX; i++) expv[i] = sw_med(i / W, i % W);
  endtask

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wen) begin
      if (int'(bus.addr) != next_addr) order_bad++;
      res[bus.addr] = bus.data_wr;
      wr_cnt++;
      next_addr++;
      if (int'(bus.addr) == W) begin
        ckpt_bad = 0;
        for (int j = 0; j < W; j++) if (res[j] !== expv[j]) ckpt_bad++;
      end
    end
  end

  task automatic start_frame(input string tag);
    @(negedge clk);
    for (int i = 0; i < NPIX; i++) res[i] = 8'hAA;
    wr_cnt = 0;
    order_bad = 0;
    next_addr = 0;
    ckpt_bad = -1;
    bus.ready = 1'b1;
    @(posedge clk);
    #1 bus.ready = 1'b0;
    chk({tag, "_busy_rise"}, int'(bus.busy), 1);
  endtask

  task automatic run_frame(input string tag);
    int cyc = 0;
    int nbad = 0;
    start_frame(tag);
    while (bus.busy && cyc < 30 * NPIX) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_timeout"}, int'(bus.busy), 0);
    chk({tag, "_writes"}, wr_cnt, NPIX);
    chk({tag, "_order"}, order_bad, 0);
    for (int i = 0; i < NPIX; i++) if (res[i] !== expv[i]) nbad++;
    chk({tag, "_pixels_bad"}, nbad, 0);
    $display("frame %s: writes %0d cycles %0d bad %0d", tag, wr_cnt, cyc, nbad);
  endtask

  initial begin
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wen", int'(bus.wen), 0);
    chk("rst_iaddr", int'(bus.iaddr), 0);
    chk("rst_addr", int'(bus.addr), 0);
    chk("rst_data_wr", int'(bus.data_wr), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);

    load_pattern(0);
    run_frame("zero");

    load_pattern(1);
    run_frame("const");
    chk("const_corner_tl", int'(res[0]), 8'h00);
    chk("const_edge_top", int'(res[1]), 8'h80);
    chk("const_interior", int'(res[W + 1]), 8'h80);
    chk("const_corner_br", int'(res[NPIX - 1]), 8'h00);

    load_pattern(2);
    run_frame("impulse");
    chk("impulse_center", int'(res[(H / 2) * W + W / 2]), 8'h10);

    load_pattern(3);
    run_frame("ramp");
    chk("ramp_interior_5_7", int'(res[5 * W + 7]), 12);
    chk("ramp_edge_top_0_5", int'(res[5]), 5);
    chk("ramp_edge_right_3_15", int'(res[3 * W + 15]), 17);
    chk("ramp_corner_tl", int'(res[0]), 0);
    chk("ramp_checkpoint_row0", ckpt_bad, 0);

    // Abort a frame part way through, then rerun from scratch.
    start_frame("abort");
    for (int i = 0; i < 30 * NPIX && wr_cnt < 60; i++) @(negedge clk);
    chk("abort_reached", int'(wr_cnt >= 60), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_wen", int'(bus.wen), 0);
    chk("abort_addr", int'(bus.addr), 0);
    $display("abort: reset applied after %0d writes", wr_cnt);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("ramp_rerun");
    chk("rerun_checkpoint_row0", ckpt_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
